// File: rtl/nios_system_cpu_0_jtag_debug_cmd_queue_pkg.sv
// Shared types and constants for the JTAG debug command queue.
// Optional statistics counters are enabled by JTAG_DEBUG_CMD_STATS_EN.
package jtag_debug_cmd_pkg;

    localparam int IR_W_DEF = 2;
    localparam int SR_W_DEF = 38;

    typedef enum logic [IR_W_DEF-1:0] {
        IR_OCIMEM    = 2'd0,
        IR_TRACEMEM  = 2'd1,
        IR_BREAK     = 2'd2,
        IR_TRACECTRL = 2'd3
    } ir_op_e;

    typedef struct packed {
        logic [IR_W_DEF-1:0] ir;
        logic [SR_W_DEF-1:0] data;
    } cmd_t;

    // Edge detection stays masked until a level held across reset release has
    // propagated through the chain and into the previous-level flop.
    function automatic int STARTUP_CYCLES(input int sync_stages);
        return sync_stages + 1;
    endfunction

endpackage

// File: rtl/nios_system_cpu_0_jtag_debug_cmd_queue_strobe_sync.sv
// Synchroniser for one TCK-domain update strobe with a maskable rising-edge output.
module jtag_debug_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic strobe_i,
    input  logic mask_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   level;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level  = sync_q[SYNC_STAGES-1];
    assign rise_o = level & ~prev_q & ~mask_i;

endmodule

// File: rtl/nios_system_cpu_0_jtag_debug_cmd_queue.sv
// Sysclk-side JTAG debug command receiver: syncs update strobes, queues commands, issues pulses.
// Define JTAG_DEBUG_CMD_STATS_EN to build the saturating accept/drop counters.
module nios_system_cpu_0_jtag_debug_cmd_queue
    import jtag_debug_cmd_pkg::*;
#(
    parameter int IR_W        = 2,
    parameter int SR_W        = 38,
    parameter int ACT_BIT     = 35,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          vs_uir,
    input  logic                          vs_udr,
    input  logic [IR_W-1:0]               ir_in,
    input  logic [SR_W-1:0]               sr,
    input  logic                          cmd_ready,
    input  logic                          ovf_clr,
    output logic [SR_W-1:0]               jdo,
    output logic [(2**IR_W)-1:0]          take_action,
    output logic [(2**IR_W)-1:0]          take_no_action,
    output logic                          cmd_pending,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [15:0]                   cnt_cmd,
    output logic [15:0]                   cnt_drop
);

    localparam int N_MODE    = 2**IR_W;
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int PW        = AW + 1;
    localparam int MASK_INIT = STARTUP_CYCLES(SYNC_STAGES);
    localparam int MASK_W    = $clog2(MASK_INIT + 1);

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [SR_W-1:0] data;
    } entry_t;

    logic [MASK_W-1:0] mask_cnt_q, mask_cnt_d;
    logic              startup_mask;
    logic              uir_rise, udr_rise;
    logic [IR_W-1:0]   ir_q, ir_d;

    entry_t            fifo_q [FIFO_DEPTH];
    entry_t            push_entry, pop_entry;
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic              empty, full, pop, push_ok, drop;

    logic [SR_W-1:0]   jdo_q, jdo_d;
    logic [N_MODE-1:0] act_q, act_d, noact_q, noact_d;
    logic              ovf_q, ovf_d;

    jtag_debug_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
        .clk      (clk),
        .reset_n  (reset_n),
        .strobe_i (vs_uir),
        .mask_i   (startup_mask),
        .rise_o   (uir_rise)
    );

    jtag_debug_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
        .clk      (clk),
        .reset_n  (reset_n),
        .strobe_i (vs_udr),
        .mask_i   (startup_mask),
        .rise_o   (udr_rise)
    );

    always_comb begin
        startup_mask = (mask_cnt_q != '0);
        mask_cnt_d   = startup_mask ? mask_cnt_q - MASK_W'(1) : mask_cnt_q;

        ir_d = uir_rise ? ir_in : ir_q;

        // Pointers carry one extra wrap bit so full and empty are distinguishable.
        empty   = (wr_q == rd_q);
        full    = ((wr_q ^ rd_q) == {1'b1, {AW{1'b0}}});
        pop     = ~empty & cmd_ready;
        push_ok = udr_rise & (~full | pop);
        drop    = udr_rise & full & ~pop;

        push_entry.ir   = ir_d;
        push_entry.data = sr;
        pop_entry       = fifo_q[rd_q[AW-1:0]];

        wr_d = wr_q + PW'(push_ok);
        rd_d = rd_q + PW'(pop);

        jdo_d   = jdo_q;
        act_d   = '0;
        noact_d = '0;
        if (pop) begin
            jdo_d                  = pop_entry.data;
            act_d[pop_entry.ir]    = pop_entry.data[ACT_BIT];
            noact_d[pop_entry.ir]  = ~pop_entry.data[ACT_BIT];
        end

        // A drop in the same cycle as a clear keeps the flag set.
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_cnt_q <= MASK_W'(MASK_INIT);
            ir_q       <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            jdo_q      <= '0;
            act_q      <= '0;
            noact_q    <= '0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            mask_cnt_q <= mask_cnt_d;
            ir_q       <= ir_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            jdo_q      <= jdo_d;
            act_q      <= act_d;
            noact_q    <= noact_d;
            ovf_q      <= ovf_d;
            if (push_ok) begin
                fifo_q[wr_q[AW-1:0]] <= push_entry;
            end
        end
    end

    assign jdo            = jdo_q;
    assign take_action    = act_q;
    assign take_no_action = noact_q;
    assign cmd_pending    = ~empty;
    assign fifo_level     = wr_q - rd_q;
    assign overflow       = ovf_q;

`ifdef JTAG_DEBUG_CMD_STATS_EN
    logic [15:0] cnt_cmd_q, cnt_drop_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_cmd_q  <= '0;
            cnt_drop_q <= '0;
        end else begin
            if (push_ok && cnt_cmd_q != 16'hFFFF) begin
                cnt_cmd_q <= cnt_cmd_q + 16'd1;
            end
            if (drop && cnt_drop_q != 16'hFFFF) begin
                cnt_drop_q <= cnt_drop_q + 16'd1;
            end
        end
    end

    assign cnt_cmd  = cnt_cmd_q;
    assign cnt_drop = cnt_drop_q;
`else
    assign cnt_cmd  = '0;
    assign cnt_drop = '0;
`endif

endmodule

// File: tb/tb_nios_system_cpu_0_jtag_debug_cmd_queue.sv
// Directed bench for the JTAG debug command queue (default parameters).
module tb_nios_system_cpu_0_jtag_debug_cmd_queue;
    import jtag_debug_cmd_pkg::*;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        vs_uir = 1'b0;
    logic        vs_udr = 1'b0;
    logic [1:0]  ir_in = '0;
    logic [37:0] sr = '0;
    logic        cmd_ready = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [37:0] jdo;
    logic [3:0]  take_action, take_no_action;
    logic        cmd_pending;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic [15:0] cnt_cmd, cnt_drop;

    nios_system_cpu_0_jtag_debug_cmd_queue dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .vs_uir         (vs_uir),
        .vs_udr         (vs_udr),
        .ir_in          (ir_in),
        .sr             (sr),
        .cmd_ready      (cmd_ready),
        .ovf_clr        (ovf_clr),
        .jdo            (jdo),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .cmd_pending    (cmd_pending),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .cnt_cmd        (cnt_cmd),
        .cnt_drop       (cnt_drop)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int exp_cmd = 0;
    int exp_drop = 0;

    typedef struct {
        int          cyc;
        logic [37:0] jdo;
        logic [3:0]  act;
        logic [3:0]  noact;
    } pulse_t;
    pulse_t pq[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if ((take_action | take_no_action) != 4'b0) begin
            pq.push_back('{cyc, jdo, take_action, take_no_action});
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [15:0] st(input int v);
`ifdef JTAG_DEBUG_CMD_STATS_EN
        return 16'(v);
`else
        return 16'd0;
`endif
    endfunction

    function automatic logic [37:0] sr_of(input int i);
        logic [37:0] s;
        s = 38'hA00 + 38'(i);
        s[35] = i[0];
        return s;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic uir_set(input logic [1:0] ir);
        ir_in = ir;
        vs_uir = 1'b1;
        tick(2);
        vs_uir = 1'b0;
        tick(3);
    endtask

    task automatic udr_strobe(input logic [37:0] s);
        sr = s;
        vs_udr = 1'b1;
        tick(2);
        vs_udr = 1'b0;
        tick(3);
    endtask

    typedef struct {
        logic [1:0]  ir;
        logic [37:0] sr;
        logic [3:0]  exp_act;
        logic [3:0]  exp_noact;
    } vec_t;
    vec_t vecs[4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{IR_BREAK,     38'h08_0000_1234, 4'b0100, 4'b0000};
        vecs[1] = '{IR_OCIMEM,    38'h00_0000_00AB, 4'b0000, 4'b0001};
        vecs[2] = '{IR_TRACEMEM,  38'h3F_FFFF_FFFF, 4'b0010, 4'b0000};
        vecs[3] = '{IR_TRACECTRL, 38'h37_0000_0001, 4'b0000, 4'b1000};

        // Reset state
        tick(3);
        chk("rst_jdo", jdo, 0);
        chk("rst_act", take_action, 0);
        chk("rst_noact", take_no_action, 0);
        chk("rst_pending", cmd_pending, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_cnt_cmd", cnt_cmd, 0);
        reset_n = 1'b1;
        cmd_ready = 1'b1;
        tick(5);

        // Single commands with latency measured from the first edge sampling vs_udr high
        for (int v = 0; v < 4; v++) begin
            int          lat;
            logic [3:0]  a, na;
            logic [37:0] d;
            lat = 0; a = '0; na = '0; d = '0;
            uir_set(vecs[v].ir);
            sr = vecs[v].sr;
            vs_udr = 1'b1;
            for (int k = 1; k <= 12 && lat == 0; k++) begin
                @(posedge clk);
                @(negedge clk);
                if ((take_action | take_no_action) != 4'b0) begin
                    lat = k; a = take_action; na = take_no_action; d = jdo;
                end
            end
            vs_udr = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_latency", v), lat, SYNC + 2);
            chk($sformatf("v%0d_act", v), a, vecs[v].exp_act);
            chk($sformatf("v%0d_noact", v), na, vecs[v].exp_noact);
            chk($sformatf("v%0d_jdo", v), d, vecs[v].sr);
            chk($sformatf("v%0d_one_cycle", v), take_action | take_no_action, 0);
            chk($sformatf("v%0d_jdo_held", v), jdo, vecs[v].sr);
            exp_cmd++;
            tick(4);
        end

        // Overflow: 5 strobes into a 4-deep queue, then drain in order
        cmd_ready = 1'b0;
        uir_set(IR_BREAK);
        for (int i = 0; i < 5; i++) udr_strobe(sr_of(i));
        exp_cmd += 4;
        exp_drop += 1;
        chk("ovf_level", fifo_level, 4);
        chk("ovf_flag", overflow, 1);
        chk("ovf_pending", cmd_pending, 1);
        chk("ovf_cnt_drop", cnt_drop, st(exp_drop));
        chk("ovf_cnt_cmd", cnt_cmd, st(exp_cmd));
        pq.delete();
        cmd_ready = 1'b1;
        tick(8);
        chk("drain_count", pq.size(), 4);
        for (int i = 0; i < 4 && i < pq.size(); i++) begin
            chk($sformatf("drain%0d_jdo", i), pq[i].jdo, sr_of(i));
            chk($sformatf("drain%0d_act", i), pq[i].act, (i % 2 == 1) ? 4'b0100 : 4'b0000);
            chk($sformatf("drain%0d_noact", i), pq[i].noact, (i % 2 == 1) ? 4'b0000 : 4'b0100);
            chk($sformatf("drain%0d_cycle", i), pq[i].cyc - pq[0].cyc, i);
        end
        chk("drain_level", fifo_level, 0);
        chk("ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // Full queue with push and pop on the same edge
        cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) udr_strobe(sr_of(20 + i));
        chk("full_level", fifo_level, 4);
        pq.delete();
        sr = 38'h01_2345_6789;
        vs_udr = 1'b1;
        tick(1);
        tick(1);
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        vs_udr = 1'b0;
        exp_cmd += 5;
        chk("coinc_level", fifo_level, 4);
        chk("coinc_ovf", overflow, 0);
        tick(3);
        chk("coinc_one_pop", pq.size(), 1);
        chk("coinc_cnt_cmd", cnt_cmd, st(exp_cmd));
        chk("coinc_cnt_drop", cnt_drop, st(exp_drop));
        cmd_ready = 1'b1;
        tick(8);
        chk("coinc_drain_count", pq.size(), 5);
        if (pq.size() == 5) begin
            chk("coinc_first_jdo", pq[0].jdo, sr_of(20));
            chk("coinc_last_jdo", pq[4].jdo, 38'h01_2345_6789);
        end

        // vs_udr held high across reset release
        vs_udr = 1'b1;
        tick(1);
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        exp_cmd = 0;
        exp_drop = 0;
        pq.delete();
        tick(10);
        chk("startup_no_pulse", pq.size(), 0);
        chk("startup_level", fifo_level, 0);
        chk("startup_cnt_cmd", cnt_cmd, st(0));
        vs_udr = 1'b0;
        tick(4);

        // Reset with three entries queued
        cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) udr_strobe(sr_of(40 + i));
        chk("mid_level_before", fifo_level, 3);
        reset_n = 1'b0;
        #1;
        chk("mid_level_reset", fifo_level, 0);
        chk("mid_pending_reset", cmd_pending, 0);
        chk("mid_cnt_reset", cnt_cmd, 0);
        tick(2);
        reset_n = 1'b1;
        cmd_ready = 1'b1;
        pq.delete();
        tick(10);
        chk("mid_no_pulse", pq.size(), 0);
        chk("mid_level_after", fifo_level, 0);

        // uir and udr rising edges in the same cycle
        uir_set(2'd1);
        pq.delete();
        ir_in = 2'd3;
        sr = 38'h08_0000_0055;
        vs_uir = 1'b1;
        vs_udr = 1'b1;
        tick(2);
        vs_uir = 1'b0;
        vs_udr = 1'b0;
        tick(4);
        exp_cmd++;
        chk("same_cycle_count", pq.size(), 1);
        if (pq.size() >= 1) begin
            chk("same_cycle_act", pq[0].act, 4'b1000);
            chk("same_cycle_noact", pq[0].noact, 4'b0000);
            chk("same_cycle_jdo", pq[0].jdo, 38'h08_0000_0055);
        end
        chk("same_cycle_cnt_cmd", cnt_cmd, st(exp_cmd));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
